mem_req_arbiter: RTL and testbench



---
 rtl/mem_req_arbiter_if.sv | 29 ++
 rtl/mem_req_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_req_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: one request/grant memory port in the core's protocol.
// The requester holds req with stable attributes until gnt; gnt, err and
// rdata are valid only in the gnt cycle.
// master modport: the side that issues requests.
// slave modport: the side that answers them.
interface mem_req_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int STRB_W = 8
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              wen;
   logic [STRB_W-1:0] strb;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              err;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, addr, wen, strb, wdata,
      input  gnt, err, rdata
   );

   modport slave (
      input  req, addr, wen, strb, wdata,
      output gnt, err, rdata
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges the imem and dmem request ports onto one memory port.
// In IDLE the winner is forwarded with zero latency. If the memory does not
// grant in that same cycle, the winner keeps the port until its grant arrives.
// TIMEOUT > 0 turns a slave that never grants into an error response after
// TIMEOUT wait cycles. TIMEOUT = 0 disables this.
// Build option ARB_ROUND_ROBIN_EN: when both masters request at once, the one
// that did not win last time wins. Without it, dmem always wins.
module mem_req_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int STRB_W  = 8,
   parameter int TIMEOUT = 0
) (
   input  logic             g_clk,
   input  logic             g_resetn,
   mem_req_arbiter_if.slave  imem,
   mem_req_arbiter_if.slave  dmem,
   mem_req_arbiter_if.master mem
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_I = 2'd1,
      OWN_D = 2'd2
   } state_t;

   localparam bit          TIMEOUT_EN  = (TIMEOUT > 0);
   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t      state;
   logic [15:0] wcnt;
   logic        lst;

   logic        pick_d;
   logic        active;
   logic        sel_d;
   logic        timeout_hit;
   logic        done;

   // Pick who owns the memory port this cycle and whether the transaction ends.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = ~lst;
`else
      pick_d = lst | 1'b1;
`endif
      active = 1'b0;
      sel_d  = 1'b0;
      case (state)
         OWN_I: begin
            active = 1'b1;
            sel_d  = 1'b0;
         end
         OWN_D: begin
            active = 1'b1;
            sel_d  = 1'b1;
         end
         default: begin
            active = imem.req | dmem.req;
            sel_d  = (imem.req & dmem.req) ? pick_d : dmem.req;
         end
      endcase
      timeout_hit = TIMEOUT_EN && (state != IDLE) && (wcnt == TIMEOUT_CNT) && !mem.gnt;
      done        = active && (mem.gnt || timeout_hit);
   end

   // Forward the selected request and route the response. Everything is held at 0 during reset.
   always_comb begin
      mem.req    = 1'b0;
      mem.addr   = '0;
      mem.wen    = 1'b0;
      mem.strb   = '0;
      mem.wdata  = '0;
      imem.gnt   = 1'b0;
      imem.err   = 1'b0;
      imem.rdata = '0;
      dmem.gnt   = 1'b0;
      dmem.err   = 1'b0;
      dmem.rdata = '0;
      if (g_resetn && active) begin
         mem.req   = 1'b1;
         mem.addr  = sel_d ? dmem.addr  : imem.addr;
         mem.wen   = sel_d ? dmem.wen   : imem.wen;
         mem.strb  = sel_d ? dmem.strb  : imem.strb;
         mem.wdata = sel_d ? dmem.wdata : imem.wdata;
      end
      if (g_resetn && done) begin
         if (sel_d) begin
            dmem.gnt   = 1'b1;
            dmem.err   = mem.gnt ? mem.err : 1'b1;
            dmem.rdata = mem.gnt ? mem.rdata : '0;
         end else begin
            imem.gnt   = 1'b1;
            imem.err   = mem.gnt ? mem.err : 1'b1;
            imem.rdata = mem.gnt ? mem.rdata : '0;
         end
      end
   end

   // Ownership FSM, saturating wait counter and last-winner tracking.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state <= IDLE;
         wcnt  <= 16'd0;
         lst   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (active) begin
                  lst <= sel_d;
                  if (!mem.gnt) begin
                     state <= sel_d ? OWN_D : OWN_I;
                     wcnt  <= TIMEOUT_EN ? 16'd1 : 16'd0;
                  end
               end
            end
            default: begin
               if (done) begin
                  state <= IDLE;
                  wcnt  <= 16'd0;
               end else if (TIMEOUT_EN && (wcnt != 16'hFFFF)) begin
                  wcnt <= wcnt + 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed and randomized checks of mem_req_arbiter
// against a transaction-level model of who owns the memory port.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_req_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic g_clk;
   logic g_resetn;

   mem_req_arbiter_if #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) imem_if ();
   mem_req_arbiter_if #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) dmem_if ();
   mem_req_arbiter_if #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) mem_if ();

   mem_req_arbiter #(
      .ADDR_W (64),
      .DATA_W (64),
      .STRB_W (8),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .g_clk   (g_clk),
      .g_resetn(g_resetn),
      .imem    (imem_if),
      .dmem    (dmem_if),
      .mem     (mem_if)
   );

   int tests = 0;
   int fails = 0;

   // Model state: owner 0=none, 1=imem, 2=dmem; age = cycles the owner has waited
   int m_owner, m_age;
   bit m_last;
   int n_owner, n_age;
   bit n_last;

   logic        e_ig, e_ie, e_dg, e_de, e_mreq, e_mwen;
   logic [63:0] e_ird, e_drd, e_maddr, e_mwdata;
   logic [7:0]  e_mstrb;

   // Free-running clock.
   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // Hard stop if the run never reaches its summary line.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Compute what the outputs must be this cycle, and the next owner/age/last.
   task automatic modelEval();
      int sel;
      bit tmo;
      e_ig = 0; e_ie = 0; e_ird = 0; e_dg = 0; e_de = 0; e_drd = 0;
      e_mreq = 0; e_maddr = 0; e_mwen = 0; e_mstrb = 0; e_mwdata = 0;
      if (!g_resetn) begin
         m_owner = 0; m_age = 0; m_last = 0;
         n_owner = 0; n_age = 0; n_last = 0;
         return;
      end
      sel = m_owner;
      if (sel == 0) begin
         if (imem_if.req && dmem_if.req) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel = m_last ? 1 : 2;
`else
            sel = 2;
`endif
         end else if (dmem_if.req) sel = 2;
         else if (imem_if.req) sel = 1;
      end
      tmo = (m_owner != 0) && (m_age == TB_TIMEOUT) && !mem_if.gnt;
      n_owner = m_owner; n_age = m_age; n_last = m_last;
      if (sel != 0) begin
         e_mreq   = 1;
         e_maddr  = (sel == 2) ? dmem_if.addr  : imem_if.addr;
         e_mwen   = (sel == 2) ? dmem_if.wen   : imem_if.wen;
         e_mstrb  = (sel == 2) ? dmem_if.strb  : imem_if.strb;
         e_mwdata = (sel == 2) ? dmem_if.wdata : imem_if.wdata;
         if (m_owner == 0) n_last = (sel == 2);
         if (mem_if.gnt || tmo) begin
            if (sel == 2) begin
               e_dg = 1; e_de = mem_if.gnt ? mem_if.err : 1'b1; e_drd = mem_if.gnt ? mem_if.rdata : 64'd0;
            end else begin
               e_ig = 1; e_ie = mem_if.gnt ? mem_if.err : 1'b1; e_ird = mem_if.gnt ? mem_if.rdata : 64'd0;
            end
            n_owner = 0; n_age = 0;
         end else if (m_owner == 0) begin
            n_owner = sel; n_age = 1;
         end else begin
            n_age = (m_age < 65535) ? m_age + 1 : 65535;
         end
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic checkOutput();
      checkVal("imem_gnt",   64'(imem_if.gnt),   64'(e_ig));
      checkVal("imem_err",   64'(imem_if.err),   64'(e_ie));
      checkVal("imem_rdata", imem_if.rdata,      e_ird);
      checkVal("dmem_gnt",   64'(dmem_if.gnt),   64'(e_dg));
      checkVal("dmem_err",   64'(dmem_if.err),   64'(e_de));
      checkVal("dmem_rdata", dmem_if.rdata,      e_drd);
      checkVal("mem_req",    64'(mem_if.req),    64'(e_mreq));
      checkVal("mem_addr",   mem_if.addr,        e_maddr);
      checkVal("mem_wen",    64'(mem_if.wen),    64'(e_mwen));
      checkVal("mem_strb",   64'(mem_if.strb),   64'(e_mstrb));
      checkVal("mem_wdata",  mem_if.wdata,       e_mwdata);
   endtask

   task automatic settle();
      #1;
      modelEval();
      checkOutput();
   endtask

   task automatic advance();
      @(posedge g_clk);
      m_owner = n_owner; m_age = n_age; m_last = n_last;
      @(negedge g_clk);
   endtask

   task automatic setImem(input logic req, input logic [63:0] addr, input logic wen,
                          input logic [7:0] strb, input logic [63:0] wdata);
      imem_if.req = req; imem_if.addr = addr; imem_if.wen = wen;
      imem_if.strb = strb; imem_if.wdata = wdata;
   endtask

   task automatic setDmem(input logic req, input logic [63:0] addr, input logic wen,
                          input logic [7:0] strb, input logic [63:0] wdata);
      dmem_if.req = req; dmem_if.addr = addr; dmem_if.wen = wen;
      dmem_if.strb = strb; dmem_if.wdata = wdata;
   endtask

   task automatic setMem(input logic gnt, input logic err, input logic [63:0] rdata);
      mem_if.gnt = gnt; mem_if.err = err; mem_if.rdata = rdata;
   endtask

   // Protocol-abiding random masters and a random slave with a given grant rate.
   task automatic applyStimulus(input int gntPct);
      if (imem_if.req && e_ig) imem_if.req = 0;
      if (dmem_if.req && e_dg) dmem_if.req = 0;
      if (!imem_if.req && $urandom_range(0, 2) == 0)
         setImem(1, {$urandom, $urandom}, 1'($urandom), 8'($urandom), {$urandom, $urandom});
      if (!dmem_if.req && $urandom_range(0, 2) == 0)
         setDmem(1, {$urandom, $urandom}, 1'($urandom), 8'($urandom), {$urandom, $urandom});
      setMem($urandom_range(0, 99) < gntPct, $urandom_range(0, 7) == 0, {$urandom, $urandom});
   endtask

   initial begin
      g_resetn = 0;
      setImem(0, 0, 0, 0, 0);
      setDmem(0, 0, 0, 0, 0);
      setMem(0, 0, 0);
      m_owner = 0; m_age = 0; m_last = 0;
      @(negedge g_clk);
      settle();
      checkVal("reset_mem_req", 64'(mem_if.req), 64'd0);
      advance();
      settle();
      advance();
      g_resetn = 1;
      settle();
      advance();

      // Continuous contention with an always-granting slave, straight after reset
      for (int c = 0; c < 4; c++) begin
         setImem(1, 64'h100, 0, 8'hFF, 64'h11);
         setDmem(1, 64'h200, 0, 8'hFF, 64'h22);
         setMem(1, 0, 64'hABCD);
         settle();
`ifdef ARB_ROUND_ROBIN_EN
         checkVal("contend_dmem_gnt", 64'(dmem_if.gnt), (c % 2 == 0) ? 64'd1 : 64'd0);
         checkVal("contend_imem_gnt", 64'(imem_if.gnt), (c % 2 == 0) ? 64'd0 : 64'd1);
`else
         checkVal("contend_dmem_gnt", 64'(dmem_if.gnt), 64'd1);
         checkVal("contend_imem_gnt", 64'(imem_if.gnt), 64'd0);
`endif
         advance();
      end
      setImem(0, 0, 0, 0, 0);
      setDmem(0, 0, 0, 0, 0);
      setMem(0, 0, 0);
      settle();
      advance();

      // Zero-latency imem read
      setImem(1, 64'h1000, 0, 8'hFF, 0);
      setMem(1, 0, 64'hDEAD_BEEF);
      settle();
      checkVal("t1_imem_gnt", 64'(imem_if.gnt), 64'd1);
      checkVal("t1_imem_rdata", imem_if.rdata, 64'hDEAD_BEEF);
      checkVal("t1_dmem_gnt", 64'(dmem_if.gnt), 64'd0);
      checkVal("t1_mem_addr", mem_if.addr, 64'h1000);
      advance();
      setImem(0, 0, 0, 0, 0);
      setMem(0, 0, 0);

      // dmem write granted after three wait cycles
      for (int c = 0; c < 4; c++) begin
         setDmem(1, 64'h2008, 1, 8'h0F, 64'h0123_4567_89AB_CDEF);
         setMem(c == 3, 0, 64'h55);
         settle();
         checkVal("t2_mem_req", 64'(mem_if.req), 64'd1);
         checkVal("t2_mem_addr", mem_if.addr, 64'h2008);
         checkVal("t2_mem_strb", 64'(mem_if.strb), 64'h0F);
         checkVal("t2_dmem_gnt", 64'(dmem_if.gnt), (c == 3) ? 64'd1 : 64'd0);
         advance();
      end
      setDmem(0, 0, 0, 0, 0);
      setMem(0, 0, 0);

      // imem locked while dmem arrives mid-wait
      setImem(1, 64'h3000, 0, 8'hFF, 0);
      settle();
      advance();
      setDmem(1, 64'h4000, 0, 8'hFF, 0);
      settle();
      checkVal("t4_lock_addr", mem_if.addr, 64'h3000);
      checkVal("t4_dmem_early", 64'(dmem_if.gnt), 64'd0);
      advance();
      setMem(1, 0, 64'h77);
      settle();
      checkVal("t4_imem_gnt", 64'(imem_if.gnt), 64'd1);
      checkVal("t4_dmem_early2", 64'(dmem_if.gnt), 64'd0);
      advance();
      setImem(0, 0, 0, 0, 0);
      settle();
      checkVal("t4_dmem_gnt", 64'(dmem_if.gnt), 64'd1);
      checkVal("t4_dmem_addr", mem_if.addr, 64'h4000);
      advance();
      setDmem(0, 0, 0, 0, 0);
      setMem(0, 0, 0);

      // Timeout against a slave that never grants
      for (int c = 0; c < 5; c++) begin
         setDmem(1, 64'h8000, 0, 8'hFF, 0);
         setMem(0, 0, 64'hFFFF_0000_FFFF_0000);
         settle();
         checkVal("t5_mem_req", 64'(mem_if.req), 64'd1);
         checkVal("t5_dmem_gnt", 64'(dmem_if.gnt), (c == 4) ? 64'd1 : 64'd0);
         if (c == 4) begin
            checkVal("t5_dmem_err", 64'(dmem_if.err), 64'd1);
            checkVal("t5_dmem_rdata", dmem_if.rdata, 64'd0);
         end
         advance();
      end
      setDmem(0, 0, 0, 0, 0);
      setImem(1, 64'h5000, 0, 8'hFF, 0);
      setMem(1, 0, 64'h99);
      settle();
      checkVal("t5_imem_after", 64'(imem_if.gnt), 64'd1);
      advance();
      setImem(0, 0, 0, 0, 0);
      setMem(0, 0, 0);

      // Reset while dmem owns the port with two wait cycles elapsed
      setDmem(1, 64'h6000, 0, 8'hFF, 0);
      settle();
      advance();
      settle();
      advance();
      g_resetn = 0;
      setMem(1, 0, 64'h1234);
      settle();
      checkVal("t6_rst_mem_req", 64'(mem_if.req), 64'd0);
      checkVal("t6_rst_dmem_gnt", 64'(dmem_if.gnt), 64'd0);
      advance();
      g_resetn = 1;
      setDmem(0, 0, 0, 0, 0);
      settle();
      checkVal("t6_no_stray_gnt", 64'(dmem_if.gnt), 64'd0);
      advance();
      setImem(1, 64'h7000, 0, 8'hFF, 0);
      settle();
      checkVal("t6_idle_serve", 64'(imem_if.gnt), 64'd1);
      advance();
      setImem(0, 0, 0, 0, 0);
      setMem(0, 0, 0);
      settle();
      advance();

      // Randomized traffic at several slave grant rates
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 500; c++) begin
            applyStimulus((p == 0) ? 60 : (p == 1) ? 20 : (p == 2) ? 0 : 100);
            settle();
            advance();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
